counter_param: RTL and testbench
================================

COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter WIDTH, default 32, counter and data width in bits (legal 4..64).
REQ-002 Parameter STEP, default 3, increment used by mode 2'b00 (legal 1..2^WIDTH-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  count/load qualifier; 0 = hold.
REQ-006 cin  input  1  cascade carry-in; counting steps only when cin=1 (tie 1 when unchained).
REQ-007 mode  input  2  00 up by STEP, 01 down by 1, 10 up by 1, 11 parallel load.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 Q  output  WIDTH  registered count.
REQ-010 rco  output  1  registered ripple-carry-out, wrap/limit indication, feeds next stage cin.
REQ-011 load  output  1  registered, high the cycle after a load was accepted.

Function
REQ-012 Each edge with enable=1 and mode=11: Q<=D, load<=1, rco<=0; cin ignored.
REQ-013 Each edge with enable=1, mode!=11, cin=1: Q<=next value per mode, computed modulo 2^WIDTH, load<=0.
REQ-014 Each edge with enable=1, mode!=11, cin=0: Q holds, rco<=0, load<=0.
REQ-015 Each edge with enable=0: Q holds, rco<=0, load<=0 regardless of mode/cin.
REQ-016 rco<=1 for exactly one cycle when the update crosses the range boundary: up modes when Q+step > 2^WIDTH-1, mode 01 when Q=0.
REQ-017 Wrap arithmetic uses WIDTH+1-bit intermediate; mode 00 from Q=2^WIDTH-1 yields Q=STEP-1.
REQ-018 Mode change takes effect on the same edge it is sampled; no pipeline latency; Q/rco/load latency = 1 cycle.
REQ-019 D, mode, cin, enable sampled only on clk rising edge; no combinational path input->output.

Reset
REQ-020 reset=0 forces Q=0, rco=0, load=0 immediately, independent of clk.
REQ-021 reset asserted mid-count discards the in-flight update; first edge after release with enable=1 acts on Q=0.
REQ-022 reset deassertion is not synchronised internally; integrator guarantees release away from clk rising edge.

Configuration
REQ-023 Macro COUNTER_SAT_EN selects boundary behaviour.
REQ-024 Without COUNTER_SAT_EN: count wraps modulo 2^WIDTH per REQ-016/017.
REQ-025 With COUNTER_SAT_EN: up modes clamp Q at 2^WIDTH-1, mode 01 clamps at 0; rco=1 every enabled counting cycle where clamp applies (level, not pulse); load behaviour unchanged.

Structure
REQ-026 Shared package counter_pkg holds mode encodings (MODE_UP_STEP=00, MODE_DOWN=01, MODE_UP=10, MODE_LOAD=11) and WIDTH/STEP defaults.
REQ-027 One combinational sub-module counter_next computes next Q and boundary flag from Q, mode, STEP; counter_param holds registers, reset and enable/cin gating.
REQ-028 Cascading N instances (rco->cin) forms an N*WIDTH counter for modes 01/10; mode 00 with STEP>1 cascades only the least-significant stage.

Verification (WIDTH=8, STEP=3 unless stated)
REQ-029 reset=0 mid-count at Q=8'h47 between edges -> Q=0, rco=0, load=0 immediately, held until release.
REQ-030 enable=1, mode=11, D=8'hFD, then mode=00 for 2 cycles -> load=1 one cycle, Q=FD, 00 (rco=1), 03 (rco=0).
REQ-031 Q=8'h01, mode=01 for 3 cycles -> Q=00, FF (rco=1), FE.
REQ-032 enable=0 or cin=0 with mode=10 at Q=8'h10 for 4 cycles -> Q stays 10, rco=0, load=0.
REQ-033 Two instances chained (rco->cin), mode=10, lower stage from FF -> upper stage increments by 1 on the cycle after lower rco.
REQ-034 COUNTER_SAT_EN defined, Q=8'hFE, mode=00 for 3 cycles -> Q=FF, FF, FF with rco=1 each cycle; with mode=01 from 01 -> 00, 00.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter slice: mode encodings and parameter defaults.
// Boundary behaviour is selected at build time by COUNTER_SAT_EN (see counter_next).
`timescale 1ns/1ps
package counter_pkg;

  localparam int              WIDTH_DEF = 32;
  localparam longint unsigned STEP_DEF  = 3;

  typedef enum logic [1:0] {
    MODE_UP_STEP = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UP      = 2'b10,
    MODE_LOAD    = 2'b11
  } mode_e;

  function automatic logic is_count_mode(input mode_e m);
    return (m != MODE_LOAD);
  endfunction

endpackage

// File: rtl/counter_param_if.sv
// Control/data bundle of one counter stage; the slave side is the counter itself.
`timescale 1ns/1ps
interface counter_param_if #(
  parameter int WIDTH = counter_pkg::WIDTH_DEF
);
  logic             enable;
  logic             cin;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             rco;
  logic             load;

  modport master (
    output enable, cin, mode, D,
    input  Q, rco, load
  );

  modport slave (
    input  enable, cin, mode, D,
    output Q, rco, load
  );
endinterface

// File: rtl/counter_next.sv
// Combinational next-count and boundary flag for one counter stage.
// With COUNTER_SAT_EN defined the count clamps at the range limits instead of wrapping.
`timescale 1ns/1ps
module counter_next
  import counter_pkg::*;
#(
  parameter int              WIDTH = WIDTH_DEF,
  parameter longint unsigned STEP  = STEP_DEF
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  output logic [WIDTH-1:0] q_next,
  output logic             bound
);

  localparam logic [WIDTH:0] STEP_EXT = {1'b0, WIDTH'(STEP)};
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

  // The extra top bit of each intermediate is the carry/borrow out of the range.
  function automatic logic [WIDTH-1:0] limit_up(input logic [WIDTH:0] sum);
`ifdef COUNTER_SAT_EN
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    return sum[WIDTH-1:0];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] limit_down(input logic [WIDTH:0] diff);
`ifdef COUNTER_SAT_EN
    return diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
    return diff[WIDTH-1:0];
`endif
  endfunction

  logic [WIDTH:0] sum_step;
  logic [WIDTH:0] sum_one;
  logic [WIDTH:0] diff_one;

  always_comb begin
    sum_step = {1'b0, q} + STEP_EXT;
    sum_one  = {1'b0, q} + ONE_EXT;
    diff_one = {1'b0, q} - ONE_EXT;
    q_next   = q;
    bound    = 1'b0;
    case (mode)
      MODE_UP_STEP: begin
        q_next = limit_up(sum_step);
        bound  = sum_step[WIDTH];
      end
      MODE_DOWN: begin
        q_next = limit_down(diff_one);
        bound  = diff_one[WIDTH];
      end
      MODE_UP: begin
        q_next = limit_up(sum_one);
        bound  = sum_one[WIDTH];
      end
      default: begin
        q_next = q;
        bound  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/counter_param.sv
// Cascadable up/down/load counter stage with registered Q, rco and load strobe.
// Boundary behaviour (wrap or clamp) follows the COUNTER_SAT_EN build macro.
`timescale 1ns/1ps
module counter_param
  import counter_pkg::*;
#(
  parameter int              WIDTH = WIDTH_DEF,
  parameter longint unsigned STEP  = STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  counter_param_if.slave  bus
);

  mode_e            mode_s;
  logic [WIDTH-1:0] cnt_nxt;
  logic             bound;
  logic [WIDTH-1:0] cnt_p1;
  logic             rco_p1;
  logic             load_p1;

  assign mode_s = mode_e'(bus.mode);

  counter_next #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next (
    .q      (cnt_p1),
    .mode   (mode_s),
    .q_next (cnt_nxt),
    .bound  (bound)
  );

  // Stage p1: load has priority over counting and ignores the cascade carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p1  <= '0;
      rco_p1  <= 1'b0;
      load_p1 <= 1'b0;
    end else if (bus.enable && !is_count_mode(mode_s)) begin
      cnt_p1  <= bus.D;
      rco_p1  <= 1'b0;
      load_p1 <= 1'b1;
    end else if (bus.enable && bus.cin) begin
      cnt_p1  <= cnt_nxt;
      rco_p1  <= bound;
      load_p1 <= 1'b0;
    end else begin
      rco_p1  <= 1'b0;
      load_p1 <= 1'b0;
    end
  end

  assign bus.Q    = cnt_p1;
  assign bus.rco  = rco_p1;
  assign bus.load = load_p1;

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param (WIDTH=8, STEP=3): directed vectors, random traffic
// against an arithmetic reference model, async reset, and a two-stage cascade.
`timescale 1ns/1ps
module tb_counter_param;
  import counter_pkg::*;

  localparam int              W    = 8;
  localparam longint unsigned ST   = 3;
  localparam longint          LIM  = longint'(1) << W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  counter_param_if #(.WIDTH(W)) bus    ();
  counter_param_if #(.WIDTH(W)) bus_lo ();
  counter_param_if #(.WIDTH(W)) bus_hi ();

  counter_param #(.WIDTH(W), .STEP(ST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  counter_param #(.WIDTH(W), .STEP(ST)) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lo.slave)
  );

  counter_param #(.WIDTH(W), .STEP(ST)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi.slave)
  );

  assign bus_hi.cin = bus_lo.rco;

  int checks = 0;
  int passed = 0;

  longint q_m;
  logic   rco_m;
  logic   load_m;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  // Reference: true integer result, then wrap or clamp into [0, 2^W-1].
  task automatic model(input logic en, input logic c, input logic [1:0] m, input logic [W-1:0] d);
    longint t;
    rco_m  = 1'b0;
    load_m = 1'b0;
    if (en) begin
      if (m == 2'b11) begin
        q_m    = longint'(d);
        load_m = 1'b1;
      end else if (c) begin
        if (m == 2'b00)      t = q_m + longint'(ST);
        else if (m == 2'b01) t = q_m - 1;
        else                 t = q_m + 1;
        rco_m = (t >= LIM) || (t < 0);
`ifdef COUNTER_SAT_EN
        if (t >= LIM) t = LIM - 1;
        if (t < 0)    t = 0;
`else
        t = ((t % LIM) + LIM) % LIM;
`endif
        q_m = t;
      end
    end
  endtask

  task automatic step(input logic en, input logic c, input logic [1:0] m,
                      input logic [W-1:0] d, input string tag);
    bus.enable = en;
    bus.cin    = c;
    bus.mode   = m;
    bus.D      = d;
    model(en, c, m, d);
    @(posedge clk);
    #1;
    check({tag, ".Q"},    64'(bus.Q),    64'(q_m));
    check({tag, ".rco"},  64'(bus.rco),  64'(rco_m));
    check({tag, ".load"}, 64'(bus.load), 64'(load_m));
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    q_m = 0; rco_m = 1'b0; load_m = 1'b0;
    #1;
    check({tag, ".Q"},    64'(bus.Q),    64'(q_m));
    check({tag, ".rco"},  64'(bus.rco),  64'(rco_m));
    check({tag, ".load"}, 64'(bus.load), 64'(load_m));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0; bus.cin = 1'b1; bus.mode = 2'b00; bus.D = '0;
    bus_lo.enable = 1'b0; bus_lo.cin = 1'b1; bus_lo.mode = 2'b00; bus_lo.D = '0;
    bus_hi.enable = 1'b0; bus_hi.mode = 2'b00; bus_hi.D = '0;
    q_m = 0; rco_m = 1'b0; load_m = 1'b0;

    #12;
    check("reset.Q",    64'(bus.Q),    64'd0);
    check("reset.rco",  64'(bus.rco),  64'd0);
    check("reset.load", 64'(bus.load), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Load then step-by-3 across the top of the range.
    step(1'b1, 1'b1, 2'b11, 8'hFD, "ld_fd");
    step(1'b1, 1'b1, 2'b00, 8'h00, "up3_a");
`ifndef COUNTER_SAT_EN
    check("up3_a.const", 64'(bus.Q), 64'h00);
`endif
    step(1'b1, 1'b1, 2'b00, 8'h00, "up3_b");
`ifndef COUNTER_SAT_EN
    check("up3_b.const", 64'(bus.Q), 64'h03);
`endif

    // Down through zero.
    step(1'b1, 1'b1, 2'b11, 8'h01, "ld_01");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b01, 8'h00, "down");

    // Hold via enable=0 and via cin=0.
    step(1'b1, 1'b1, 2'b11, 8'h10, "ld_10");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b10, 8'hAA, "hold_en");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b10, 8'hAA, "hold_cin");
    check("hold.const", 64'(bus.Q), 64'h10);

    // Asynchronous reset mid-count, held across an edge, then count from zero.
    step(1'b1, 1'b1, 2'b11, 8'h47, "ld_47");
    #2;
    reset = 1'b0;
    q_m = 0; rco_m = 1'b0; load_m = 1'b0;
    #1;
    check("arst.Q",    64'(bus.Q),    64'd0);
    check("arst.rco",  64'(bus.rco),  64'd0);
    check("arst.load", 64'(bus.load), 64'd0);
    bus.mode = 2'b10;
    @(posedge clk);
    #1;
    check("arst_hold.Q", 64'(bus.Q), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b1, 2'b10, 8'h00, "post_rst");
    check("post_rst.const", 64'(bus.Q), 64'h01);

`ifdef COUNTER_SAT_EN
    step(1'b1, 1'b1, 2'b11, 8'hFE, "sat_ld_fe");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'b00, 8'h00, "sat_up");
      check("sat_up.const", 64'(bus.Q), 64'hFF);
    end
    step(1'b1, 1'b1, 2'b11, 8'h01, "sat_ld_01");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'b01, 8'h00, "sat_dn");
      check("sat_dn.const", 64'(bus.Q), 64'h00);
    end
`endif

    // Random traffic, biased towards counting and the range edges.
    for (int i = 0; i < 400; i++) begin
      logic       en, c;
      logic [1:0] m;
      logic [W-1:0] d;
      en = ($urandom_range(0, 7) != 0);
      c  = ($urandom_range(0, 5) != 0);
      m  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) m = 2'b11;
      d  = ($urandom_range(0, 1) == 1) ? 8'(W'($urandom_range(250, 255) & 8'hFF))
                                       : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 4));
      step(en, c, m, d, "rnd");
      if ($urandom_range(0, 49) == 0) async_reset_pulse("rnd_rst");
    end

    // Two-stage cascade: lower rco feeds upper cin.
    @(negedge clk);
    bus_lo.enable = 1'b1; bus_lo.mode = 2'b11; bus_lo.D = 8'hFF;
    bus_hi.enable = 1'b1; bus_hi.mode = 2'b11; bus_hi.D = 8'h05;
    @(posedge clk); #1;
    check("chain_ld.lo", 64'(bus_lo.Q), 64'hFF);
    check("chain_ld.hi", 64'(bus_hi.Q), 64'h05);
    bus_lo.mode = 2'b10;
    bus_hi.mode = 2'b10;
    @(posedge clk); #1;
    check("chain1.lo_rco", 64'(bus_lo.rco), 64'd1);
    check("chain1.hi",     64'(bus_hi.Q),   64'h05);
    @(posedge clk); #1;
    check("chain2.hi",     64'(bus_hi.Q),   64'h06);
    @(posedge clk); #1;
`ifdef COUNTER_SAT_EN
    check("chain3.hi",     64'(bus_hi.Q),   64'h07);
`else
    check("chain3.lo",     64'(bus_lo.Q),   64'h02);
    check("chain3.hi",     64'(bus_hi.Q),   64'h06);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
